// File: rtl/output_layer_mac.sv
// output_layer_mac: 10 parallel signed MACs over an N_IN-beat activation stream, requantised to unsigned 8-bit scores.
// Build option: define OUTPUT_LAYER_ROUND_EN for round-half-up requantisation (default: floor shift).
module output_layer_mac #(
  parameter int N_IN  = 64,
  parameter int ACC_W = 24,
  parameter int SHIFT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic [79:0] w_data,
  output logic        busy,
  output logic        out_valid,
  output logic [7:0]  mac0,
  output logic [7:0]  mac1,
  output logic [7:0]  mac2,
  output logic [7:0]  mac3,
  output logic [7:0]  mac4,
  output logic [7:0]  mac5,
  output logic [7:0]  mac6,
  output logic [7:0]  mac7,
  output logic [7:0]  mac8,
  output logic [7:0]  mac9
);
  localparam int CNT_W = N_IN > 1 ? $clog2(N_IN) : 1;
  typedef enum logic [1:0] {IDLE, ACCUM, REQUANT, DONE} state_t;
  state_t                  r_state, w_next;
  logic [CNT_W-1:0]        r_count;
  logic signed [ACC_W-1:0] r_acc [10];
  logic [7:0]              r_mac [10];
  logic signed [ACC_W-1:0] w_prod [10];
  logic [7:0]              w_sat [10];
  logic                    w_fire, w_last;
  assign in_ready  = r_state == ACCUM;
  assign busy      = r_state != IDLE;
  assign out_valid = r_state == DONE;
  assign w_fire    = in_valid & in_ready;
  assign w_last    = r_count == CNT_W'(N_IN - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? ACCUM : IDLE;
      ACCUM:   w_next = (w_fire && w_last) ? REQUANT : ACCUM;
      REQUANT: w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  for (genvar k = 0; k < 10; k++) begin : g_neuron
    logic signed [16:0]    w_mul;
    logic signed [ACC_W:0] w_s;
    assign w_mul     = $signed({1'b0, in_data}) * $signed(w_data[8*k +: 8]);
    assign w_prod[k] = {{(ACC_W-17){w_mul[16]}}, w_mul};
`ifdef OUTPUT_LAYER_ROUND_EN
    // Widened by one bit so the rounding offset can never wrap the accumulator.
    assign w_s = $signed({r_acc[k][ACC_W-1], r_acc[k]} + (ACC_W+1)'(2 ** (SHIFT - 1))) >>> SHIFT;
`else
    assign w_s = $signed({r_acc[k][ACC_W-1], r_acc[k]}) >>> SHIFT;
`endif
    assign w_sat[k] = w_s[ACC_W] ? 8'd0 : (w_s > $signed((ACC_W+1)'(255))) ? 8'hFF : w_s[7:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_count <= '0;
      for (int i = 0; i < 10; i++) begin
        r_acc[i] <= '0;
        r_mac[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_count <= '0;
        for (int i = 0; i < 10; i++) r_acc[i] <= '0;
      end else if (w_fire) begin
        r_count <= r_count + CNT_W'(1);
        for (int i = 0; i < 10; i++) r_acc[i] <= r_acc[i] + w_prod[i];
      end
      if (r_state == REQUANT)
        for (int i = 0; i < 10; i++) r_mac[i] <= w_sat[i];
    end
  end
  assign mac0 = r_mac[0];
  assign mac1 = r_mac[1];
  assign mac2 = r_mac[2];
  assign mac3 = r_mac[3];
  assign mac4 = r_mac[4];
  assign mac5 = r_mac[5];
  assign mac6 = r_mac[6];
  assign mac7 = r_mac[7];
  assign mac8 = r_mac[8];
  assign mac9 = r_mac[9];
endmodule

// File: tb/tb_output_layer_mac.sv
// tb_output_layer_mac: randomized + directed frames, scoreboard queue of expected scores checked by a monitor.
// SHIFT=4 is used so the rounding cases (acc=24, acc=23) are exercised alongside saturation and clamping.
module tb_output_layer_mac;
  localparam int N = 64, AW = 24, SH = 4;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic in_ready, busy, out_valid;
  logic [7:0] in_data = '0;
  logic [79:0] w_data = '0;
  logic [7:0] mac0, mac1, mac2, mac3, mac4, mac5, mac6, mac7, mac8, mac9;
  logic [79:0] w_macs;
  int errs = 0, checks = 0, cyc = 0, last_acc = 0;
  logic [79:0] exp_q[$];
  logic [79:0] exp_hold = '0;
  logic [7:0]  fd [N];
  logic [79:0] fw [N];
  output_layer_mac #(.N_IN(N), .ACC_W(AW), .SHIFT(SH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .w_data(w_data), .busy(busy), .out_valid(out_valid),
    .mac0(mac0), .mac1(mac1), .mac2(mac2), .mac3(mac3), .mac4(mac4),
    .mac5(mac5), .mac6(mac6), .mac7(mac7), .mac8(mac8), .mac9(mac9));
  assign w_macs = {mac9, mac8, mac7, mac6, mac5, mac4, mac3, mac2, mac1, mac0};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic fail(input string name);
    checks++;
    errs++;
    $display("FAIL %s", name);
  endtask
  // Reference: plain integer dot products, shift, clamp to 0..255.
  function automatic logic [79:0] model();
    logic [79:0] r = '0;
    int acc, s;
    byte w;
    for (int k = 0; k < 10; k++) begin
      acc = 0;
      for (int b = 0; b < N; b++) begin
        w = fw[b][8*k +: 8];
        acc += int'(fd[b]) * int'(w);
      end
`ifdef OUTPUT_LAYER_ROUND_EN
      s = (acc + (1 <<< (SH - 1))) >>> SH;
`else
      s = acc >>> SH;
`endif
      r[8*k +: 8] = s < 0 ? 8'd0 : s > 255 ? 8'd255 : 8'(s);
    end
    return r;
  endfunction
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) fail("unexpected out_valid");
        else begin
          exp_hold = exp_q.pop_front();
          for (int k = 0; k < 10; k++)
            check($sformatf("mac%0d", k), 80'(w_macs[8*k +: 8]), 80'(exp_hold[8*k +: 8]));
          // out_valid is seen in the second cycle after the edge that took the last beat.
          check("latency", 80'(cyc - last_acc), 80'(1));
        end
      end else check("hold", w_macs, exp_hold);
    end
  end
  task automatic clear_frame();
    for (int b = 0; b < N; b++) begin
      fd[b] = '0;
      fw[b] = '0;
    end
  endtask
  task automatic fill_rand();
    for (int b = 0; b < N; b++) begin
      fd[b] = 8'($urandom());
      for (int k = 0; k < 10; k++) fw[b][8*k +: 8] = 8'($urandom_range(0, 31)) - 8'd16;
    end
  endtask
  // mode 0: always valid; 1: valid pattern 1,0,0,...; 2: random valid
  task automatic run_frame(input int mode, input bit mid_start, input int abort_at);
    int b, n;
    logic acc;
    if (abort_at < 0) exp_q.push_back(model());
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    b = 0;
    n = 0;
    while (b < N && n < 4 * N + 20) begin
      in_valid = mode == 0 ? 1'b1 : mode == 1 ? (n % 3 == 0) : 1'($urandom_range(0, 1));
      in_data  = fd[b];
      w_data   = fw[b];
      start    = mid_start && b == N / 2;
      @(negedge clk) acc = in_valid && in_ready;
      @(posedge clk); #1 n++;
      if (acc) begin
        b++;
        last_acc = cyc;
      end
      if (abort_at >= 0 && b == abort_at) break;
    end
    in_valid = 0;
    start = 0;
    if (abort_at >= 0) begin
      rst_n = 0;
      #1 check("abort macs", w_macs, '0);
      check("abort flags", 80'({in_ready, busy, out_valid}), '0);
      exp_hold = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
    end else begin
      if (b < N) fail("beat acceptance timeout");
      n = 0;
      while (busy && n < 20) begin
        @(posedge clk); #1 n++;
      end
      if (busy) fail("frame completion timeout");
    end
  endtask
  initial begin
    rst_n = 0;
    start = 1;
    in_valid = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset macs", w_macs, '0);
    check("reset flags", 80'({in_ready, busy, out_valid}), '0);
    start = 0;
    in_valid = 0;
    @(posedge clk); #1 rst_n = 1;
    clear_frame();
    for (int b = 0; b < 4; b++) begin
      fd[b] = 8'd10;
      fw[b][7:0] = 8'd3;
      fw[b][15:8] = 8'hFE;
    end
    run_frame(0, 0, -1);
    clear_frame();
    fd[0] = 8'd24;
    fw[0][7:0] = 8'd1;
    fd[1] = 8'd23;
    fw[1][15:8] = 8'd1;
    run_frame(0, 0, -1);
    for (int b = 0; b < N; b++) begin
      fd[b] = 8'd255;
      fw[b] = {10{8'd127}};
    end
    run_frame(0, 0, -1);
    for (int b = 0; b < N; b++) fw[b] = {10{8'h80}};
    run_frame(0, 0, -1);
    fill_rand();
    run_frame(1, 1, -1);
    for (int i = 0; i < 5; i++) begin
      fill_rand();
      run_frame(2, i[0], -1);
    end
    fill_rand();
    run_frame(0, 0, 30);
    repeat (3) @(posedge clk);
    run_frame(0, 0, -1);
    repeat (5) @(posedge clk);
    check("queue drained", 80'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
